// File: rtl/psec_pkg.sv
// Shared state encoding and MODE (group size) encoding for the PSEC channel trigger sequencer.
package psec_pkg;

  typedef enum logic [2:0] {
    INIT,
    SAMPLING,
    SLOW_ONLY,
    STOPPED,
    READOUT
  } seq_state_t;

  localparam logic [1:0] MODE_G1   = 2'd0;
  localparam logic [1:0] MODE_G2   = 2'd1;
  localparam logic [1:0] MODE_G4   = 2'd2;
  localparam logic [1:0] MODE_GALL = 2'd3;

  // log2 of the group size, clamped so a group never exceeds the bank count
  function automatic int unsigned grp_log2(input logic [1:0] mode, input int unsigned max_log2);
    int unsigned r;
    case (mode)
      MODE_G1: r = 32'd0;
      MODE_G2: r = 32'd1;
      MODE_G4: r = 32'd2;
      default: r = max_log2;
    endcase
    if (r > max_log2) r = max_log2;
    return r;
  endfunction

endpackage

// File: rtl/psec_ser_frame.sv
// Width-FW load/shift serializer, LSB first, with a done flag once the whole frame has gone out.
module psec_ser_frame #(
  parameter int unsigned FW = 53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic [FW-1:0] data,
  output logic          ser,
  output logic          done
);

  localparam int unsigned CW = $clog2(FW + 1);

  logic [FW-1:0] sreg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
    end else if (shift && !done) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

  assign ser  = sreg[0];
  assign done = (cnt == CW'(FW));

endmodule

// File: rtl/psec_ch_trig_seq.sv
// Per-channel trigger sequencer: walks NUM_BANKS fast banks in groups on delayed, edge-qualified
// discriminator events, then falls back to the slow bank, with a serial counter readout.
module psec_ch_trig_seq
  import psec_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned DELAY_W   = 5,
  parameter int unsigned HOLD_W    = 8
) (
  input  logic                           FCLK,
  input  logic                           RSTB,
  input  logic                           INST_START,
  input  logic                           INST_STOP,
  input  logic                           INST_READOUT,
  input  logic                           DISCRIMINATOR_OUTPUT,
  input  logic                           DISCRIMINATOR_POLARITY,
  input  logic [1:0]                     MODE,
  input  logic [DELAY_W-1:0]             TRIG_DELAY,
  input  logic [HOLD_W-1:0]              HOLDOFF,
  input  logic [(NUM_BANKS+1)*CNT_W-1:0] CNT,
  input  logic                           SER_SHIFT,
  output logic [NUM_BANKS-1:0]           TRIGGER,
  output logic [NUM_BANKS-1:0]           TRIGGERC,
  output logic                           TRIGGERE,
  output logic                           STOP_REQUEST,
  output logic                           EXTRA_TRIG,
  output logic                           CNT_SER,
  output logic                           SER_DONE
);

  localparam int unsigned DEPTH = 2 ** DELAY_W;
  localparam int unsigned GW    = $clog2(NUM_BANKS);
  localparam int unsigned LW    = $clog2(GW + 1);
  localparam int unsigned TW    = $clog2(NUM_BANKS + 1);
  localparam int unsigned FW    = TW + (NUM_BANKS + 1) * CNT_W;

  seq_state_t        state;
  logic [GW-1:0]     grp;
  logic [GW-1:0]     last_grp;
  logic [LW-1:0]     glog;
  logic [TW-1:0]     trig_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              disc_q;
  logic [DEPTH-1:1]  hist_r;
  logic [DEPTH-1:0]  hist;
  logic              lvl;
  logic              lvl_prev;
  logic              armed;
  logic              event_hit;
  logic              ser_load;
  logic              ser_shift;

  // hist[0] is disc_q itself, so tap d sees the sample taken d cycles earlier
  assign hist      = {hist_r, disc_q};
  assign lvl       = hist[TRIG_DELAY] ^ DISCRIMINATOR_POLARITY;
  assign armed     = (hold_cnt == '0);
  assign event_hit = lvl & ~lvl_prev & armed & ((state == SAMPLING) || (state == SLOW_ONLY));
  assign last_grp  = GW'((NUM_BANKS >> glog) - 1);

  always_ff @(posedge FCLK or negedge RSTB) begin
    if (!RSTB) begin
      disc_q   <= 1'b0;
      hist_r   <= '0;
      lvl_prev <= 1'b0;
    end else begin
      disc_q   <= DISCRIMINATOR_OUTPUT;
      hist_r   <= hist[DEPTH-2:0];
      lvl_prev <= lvl;
    end
  end

  always_ff @(posedge FCLK or negedge RSTB) begin
    if (!RSTB) begin
      state        <= INIT;
      grp          <= '0;
      glog         <= '0;
      trig_cnt     <= '0;
      hold_cnt     <= '0;
      STOP_REQUEST <= 1'b0;
      EXTRA_TRIG   <= 1'b0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (INST_START) begin
        state        <= SAMPLING;
        grp          <= '0;
        trig_cnt     <= '0;
        hold_cnt     <= HOLDOFF;
        glog         <= LW'(grp_log2(MODE, GW));
        STOP_REQUEST <= 1'b0;
        EXTRA_TRIG   <= 1'b0;
      end else if (INST_STOP) begin
        state <= STOPPED;
      end else if (INST_READOUT) begin
        if (state != INIT) state <= READOUT;
      end else if (event_hit) begin
        if (state == SAMPLING) begin
          trig_cnt <= trig_cnt + 1'b1;
          if (grp != last_grp) begin
            grp      <= grp + 1'b1;
            hold_cnt <= HOLDOFF;
          end else begin
            state        <= SLOW_ONLY;
            STOP_REQUEST <= 1'b1;
          end
        end else begin
          EXTRA_TRIG <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    TRIGGER  = '1;
    TRIGGERC = '1;
    TRIGGERE = 1'b1;
    case (state)
      SAMPLING: begin
        TRIGGERE = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (GW'(b >> glog) == grp) begin
            TRIGGER[b]  = 1'b0;
            TRIGGERC[b] = 1'b0;
          end else if (GW'(b >> glog) > grp) begin
            TRIGGERC[b] = 1'b0;
          end
        end
      end
      SLOW_ONLY: TRIGGERE = 1'b0;
      default: ;
    endcase
  end

  // load mirrors the command priority: START/STOP pre-empt READOUT, and INIT ignores it
  assign ser_load  = INST_READOUT & ~INST_START & ~INST_STOP & (state != INIT);
  assign ser_shift = SER_SHIFT & (state == READOUT);

  psec_ser_frame #(
    .FW(FW)
  ) u_ser (
    .clk  (FCLK),
    .rst_n(RSTB),
    .load (ser_load),
    .shift(ser_shift),
    .data ({trig_cnt, CNT}),
    .ser  (CNT_SER),
    .done (SER_DONE)
  );

endmodule

// File: tb/tb_psec_ch_trig_seq.sv
// Bench for psec_ch_trig_seq: directed timing cases plus randomized runs against a bank-walk model.
module tb_psec_ch_trig_seq;

  localparam int NB   = 4;
  localparam int CW   = 10;
  localparam int DW   = 5;
  localparam int HW   = 8;
  localparam int TW   = $clog2(NB + 1);
  localparam int CNTW = (NB + 1) * CW;
  localparam int FW   = TW + CNTW;

  logic            FCLK = 1'b0;
  logic            RSTB;
  logic            INST_START, INST_STOP, INST_READOUT;
  logic            DISCRIMINATOR_OUTPUT, DISCRIMINATOR_POLARITY;
  logic [1:0]      MODE;
  logic [DW-1:0]   TRIG_DELAY;
  logic [HW-1:0]   HOLDOFF;
  logic [CNTW-1:0] CNT;
  logic            SER_SHIFT;
  logic [NB-1:0]   TRIGGER, TRIGGERC;
  logic            TRIGGERE, STOP_REQUEST, EXTRA_TRIG, CNT_SER, SER_DONE;

  int checks   = 0;
  int failures = 0;

  // model: m_st 0 = all banks stopped (INIT/STOPPED/READOUT), 1 = sampling, 2 = slow only
  int m_st, m_grp, m_cnt, m_G;
  bit m_stop, m_extra;

  psec_ch_trig_seq #(
    .NUM_BANKS(NB),
    .CNT_W    (CW),
    .DELAY_W  (DW),
    .HOLD_W   (HW)
  ) dut (
    .FCLK                  (FCLK),
    .RSTB                  (RSTB),
    .INST_START            (INST_START),
    .INST_STOP             (INST_STOP),
    .INST_READOUT          (INST_READOUT),
    .DISCRIMINATOR_OUTPUT  (DISCRIMINATOR_OUTPUT),
    .DISCRIMINATOR_POLARITY(DISCRIMINATOR_POLARITY),
    .MODE                  (MODE),
    .TRIG_DELAY            (TRIG_DELAY),
    .HOLDOFF               (HOLDOFF),
    .CNT                   (CNT),
    .SER_SHIFT             (SER_SHIFT),
    .TRIGGER               (TRIGGER),
    .TRIGGERC              (TRIGGERC),
    .TRIGGERE              (TRIGGERE),
    .STOP_REQUEST          (STOP_REQUEST),
    .EXTRA_TRIG            (EXTRA_TRIG),
    .CNT_SER               (CNT_SER),
    .SER_DONE              (SER_DONE)
  );

  always #5 FCLK = ~FCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge FCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_vec(input bit chain);
    logic [NB-1:0] v;
    int g;
    v = '1;
    if (m_st == 1) begin
      for (int b = 0; b < NB; b++) begin
        g = b / m_G;
        v[b] = chain ? (g < m_grp) : (g != m_grp);
      end
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".trig"},  64'(TRIGGER),      64'(exp_vec(1'b0)));
    chk({tag, ".trigc"}, 64'(TRIGGERC),     64'(exp_vec(1'b1)));
    chk({tag, ".trige"}, 64'(TRIGGERE),     64'(m_st == 0));
    chk({tag, ".stop"},  64'(STOP_REQUEST), 64'(m_stop));
    chk({tag, ".extra"}, 64'(EXTRA_TRIG),   64'(m_extra));
  endtask

  task automatic model_start(input int mode);
    m_st = 1; m_grp = 0; m_cnt = 0; m_stop = 0; m_extra = 0;
    m_G = (mode == 0) ? 1 : (mode == 1) ? 2 : (mode == 2) ? 4 : NB;
    if (m_G > NB) m_G = NB;
  endtask

  task automatic model_event();
    if (m_st == 1) begin
      m_cnt++;
      if (m_grp < NB / m_G - 1) m_grp++;
      else begin
        m_st   = 2;
        m_stop = 1;
      end
    end else if (m_st == 2) begin
      m_extra = 1;
    end
  endtask

  task automatic do_start(input int mode, input int h, input int d);
    tick(10);
    MODE = 2'(mode); HOLDOFF = HW'(h); TRIG_DELAY = DW'(d);
    INST_START = 1'b1;
    tick(1);
    INST_START = 1'b0;
    model_start(mode);
    check_all("start");
  endtask

  // one-cycle pulse; checks the edge before and the edge at which the event must land
  task automatic do_pulse(input int d, input int h, input string tag);
    DISCRIMINATOR_OUTPUT = 1'b1;
    tick(1);
    DISCRIMINATOR_OUTPUT = 1'b0;
    tick(d);
    check_all({tag, ".pre"});
    tick(1);
    model_event();
    check_all({tag, ".post"});
    tick(h + 2);
  endtask

  task automatic do_readout(input logic [CNTW-1:0] cv, input string tag);
    logic [FW-1:0] got, want;
    CNT = cv;
    INST_READOUT = 1'b1;
    tick(1);
    INST_READOUT = 1'b0;
    m_st = 0;
    check_all({tag, ".rdst"});
    want = {TW'(m_cnt), cv};
    got  = '0;
    for (int j = 0; j < FW; j++) begin
      got[j] = CNT_SER;
      if (j == FW - 1) chk({tag, ".notdone"}, 64'(SER_DONE), 64'(0));
      SER_SHIFT = 1'b1;
      tick(1);
      SER_SHIFT = 1'b0;
    end
    chk({tag, ".frame"}, 64'(got), 64'(want));
    chk({tag, ".done"}, 64'(SER_DONE), 64'(1));
    SER_SHIFT = 1'b1;
    tick(1);
    SER_SHIFT = 1'b0;
    chk({tag, ".done_hold"}, 64'(SER_DONE), 64'(1));
  endtask

  initial begin
    logic [CNTW-1:0] cv;
    int mode, h, d, np;

    RSTB = 1'b0; INST_START = 0; INST_STOP = 0; INST_READOUT = 0;
    DISCRIMINATOR_OUTPUT = 0; DISCRIMINATOR_POLARITY = 0;
    MODE = '0; TRIG_DELAY = '0; HOLDOFF = '0; CNT = '0; SER_SHIFT = 0;
    m_st = 0; m_grp = 0; m_cnt = 0; m_G = 1; m_stop = 0; m_extra = 0;

    // reset values
    tick(3);
    check_all("rst");
    chk("rst.ser", 64'(CNT_SER), 64'(0));
    chk("rst.done", 64'(SER_DONE), 64'(0));
    RSTB = 1'b1;
    tick(2);

    // readout from INIT is ignored
    CNT = '1;
    INST_READOUT = 1'b1;
    tick(1);
    INST_READOUT = 1'b0;
    check_all("init_rd");
    chk("init_rd.ser", 64'(CNT_SER), 64'(0));

    // group size 1: walk all four banks, then slow-only and an extra trigger
    do_start(0, 0, 0);
    for (int i = 0; i < 5; i++) do_pulse(0, 0, $sformatf("g1_p%0d", i));

    // group size 2 with holdoff 10: pulses at start+5 and start+9 rejected, start+12 accepted
    do_start(1, 10, 0);
    tick(4);
    DISCRIMINATOR_OUTPUT = 1'b1; tick(1); DISCRIMINATOR_OUTPUT = 1'b0;
    tick(1);
    check_all("hold_p5");
    tick(2);
    DISCRIMINATOR_OUTPUT = 1'b1; tick(1); DISCRIMINATOR_OUTPUT = 1'b0;
    tick(1);
    check_all("hold_p9");
    tick(1);
    DISCRIMINATOR_OUTPUT = 1'b1; tick(1); DISCRIMINATOR_OUTPUT = 1'b0;
    tick(1);
    model_event();
    check_all("hold_p12");
    chk("hold_p12.vec", 64'(TRIGGER), 64'(4'b0011));

    // delay 7 with a held level: exactly one event, exactly 8 edges after the sample
    do_start(0, 0, 7);
    DISCRIMINATOR_OUTPUT = 1'b1;
    tick(1);
    tick(7);
    check_all("d7.pre");
    tick(1);
    model_event();
    check_all("d7.post");
    tick(12);
    check_all("d7.held");
    DISCRIMINATOR_OUTPUT = 1'b0;
    tick(10);
    check_all("d7.release");

    // start on the same edge as an event: start wins
    do_start(0, 0, 0);
    DISCRIMINATOR_OUTPUT = 1'b1;
    tick(1);
    DISCRIMINATOR_OUTPUT = 1'b0;
    INST_START = 1'b1;
    tick(1);
    INST_START = 1'b0;
    model_start(0);
    check_all("collide");
    tick(3);
    check_all("collide.after");
    do_readout('0, "collide");

    // two triggers then frame readout with fields 1..5
    do_start(0, 0, 0);
    do_pulse(0, 0, "rd_p0");
    do_pulse(0, 0, "rd_p1");
    for (int i = 0; i < NB + 1; i++) cv[i*CW +: CW] = CW'(i + 1);
    do_readout(cv, "rd");

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      mode = int'($urandom_range(0, 3));
      h    = int'($urandom_range(0, 5));
      d    = int'($urandom_range(0, 7));
      np   = int'($urandom_range(1, 6));
      do_start(mode, h, d);
      tick(h);
      for (int p = 0; p < np; p++) do_pulse(d, h, $sformatf("rnd%0d_p%0d", it, p));
      if ($urandom_range(0, 1) == 1) begin
        INST_STOP = 1'b1;
        tick(1);
        INST_STOP = 1'b0;
        m_st = 0;
        check_all($sformatf("rnd%0d_stop", it));
      end
      cv = CNTW'({$urandom(), $urandom()});
      do_readout(cv, $sformatf("rnd%0d", it));
    end

    // asynchronous reset in the middle of sampling, grp = 2
    do_start(0, 0, 0);
    do_pulse(0, 0, "ar_p0");
    do_pulse(0, 0, "ar_p1");
    #2;
    RSTB = 1'b0;
    #1;
    m_st = 0; m_grp = 0; m_cnt = 0; m_stop = 0; m_extra = 0;
    check_all("arst");
    chk("arst.ser", 64'(CNT_SER), 64'(0));
    chk("arst.done", 64'(SER_DONE), 64'(0));
    tick(2);
    RSTB = 1'b1;
    tick(2);
    check_all("arst.release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psec_ch_trig_seq.md
# psec_ch_trig_seq

Parametrised per-channel trigger sequencer for the PSEC sampling front end. It generalises the fixed four-bank fast-buffer controller to NUM_BANKS fast banks in programmable group sizes, plus one slow bank. It adds a programmable arm/re-arm holdoff, edge-qualified delayed triggering and a full-frame serial counter readout. The block is fully synchronous to FCLK and sits between the synchronised discriminator and the analog write-strobe latches.

## Interface
- NUM_BANKS, 4, number of fast banks; power of two, minimum 4.
- CNT_W, 10, width of each bank's counter value.
- DELAY_W, 5, width of TRIG_DELAY; history depth is 2**DELAY_W.
- HOLD_W, 8, width of HOLDOFF.
- FCLK  in  1  sole clock; all logic is on its rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- INST_START, INST_STOP, INST_READOUT  in  1 each  single-FCLK-cycle command pulses, already synchronised.
- DISCRIMINATOR_OUTPUT  in  1  discriminator level.
- DISCRIMINATOR_POLARITY  in  1  1 inverts the discriminator.
- MODE  in  2  group size G: 0 gives 1, 1 gives 2, 2 gives 4, 3 gives NUM_BANKS. If G exceeds NUM_BANKS, G = NUM_BANKS.
- TRIG_DELAY  in  DELAY_W  trigger tap, in FCLK cycles.
- HOLDOFF  in  HOLD_W  arm/re-arm holdoff, in FCLK cycles.
- CNT  in  (NUM_BANKS+1)*CNT_W  counter values; bank 0 is in the LSBs and the slow bank is at the top.
- SER_SHIFT  in  1  one-cycle strobe that advances the serial readout.
- TRIGGER  out  NUM_BANKS  per-bank write-stop; 1 means stopped.
- TRIGGERC  out  NUM_BANKS  per-bank chain-stop; 1 means chain broken.
- TRIGGERE  out  1  slow-bank stop.
- STOP_REQUEST  out  1  all fast groups have triggered.
- EXTRA_TRIG  out  1  sticky flag: a trigger arrived while in SLOW_ONLY.
- CNT_SER  out  1  serial readout bit.
- SER_DONE  out  1  whole frame has been shifted out.

## Operation
- States: INIT, SAMPLING, SLOW_ONLY, STOPPED, READOUT. There is also a group index grp in 0..NG-1, where NG = NUM_BANKS/G.
- Command priority within one cycle: RSTB, then INST_START, then INST_STOP, then INST_READOUT, then trigger.
- INST_START (accepted from any state):
  - Go to SAMPLING with grp=0 and trig_cnt=0.
  - Load hold_cnt=HOLDOFF.
  - Clear STOP_REQUEST and EXTRA_TRIG.
  - Capture MODE into the group size. MODE changes mid-run are ignored.
- Trigger path:
  - disc_q registers DISCRIMINATOR_OUTPUT.
  - hist is a shift register, with hist[0]=disc_q.
  - L = hist[TRIG_DELAY] ^ DISCRIMINATOR_POLARITY. L_prev is L registered.
  - Event = L & ~L_prev & armed & (state is SAMPLING or SLOW_ONLY), where armed means hold_cnt==0.
  - hold_cnt decrements by one per cycle while nonzero.
- Event in SAMPLING:
  - trig_cnt increments.
  - If grp<NG-1: grp increments and hold_cnt reloads to HOLDOFF.
  - Otherwise: go to SLOW_ONLY and set STOP_REQUEST.
- Event in SLOW_ONLY: set EXTRA_TRIG. The state does not change.
- INST_STOP: go to STOPPED. grp and trig_cnt hold.
- INST_READOUT:
  - From INIT: ignored.
  - From any other state: go to READOUT and load sreg = {trig_cnt, CNT}. Frame width FW = clog2(NUM_BANKS+1) + (NUM_BANKS+1)*CNT_W.
  - Clear the shift counter.
- Serial readout:
  - CNT_SER = sreg[0]; bits go out LSB first.
  - Each SER_SHIFT in READOUT shifts sreg right and increments the shift counter.
  - When the shift counter reaches FW, SER_DONE=1 and further SER_SHIFT is ignored.
- Output decode (combinational from registered state), with bank b in group b/G:
  - INIT, STOPPED, READOUT: all TRIGGER, TRIGGERC and TRIGGERE are 1.
  - SAMPLING, group below grp: TRIGGER=1, TRIGGERC=1.
  - SAMPLING, group equal to grp: TRIGGER=0, TRIGGERC=0.
  - SAMPLING, group above grp: TRIGGER=1, TRIGGERC=0.
  - SLOW_ONLY: all TRIGGER and TRIGGERC are 1.
  - TRIGGERE=0 in SAMPLING and SLOW_ONLY.
- Reset values: state=INIT, grp=0, trig_cnt=0, hold_cnt=0, hist=0, L_prev=0, sreg=0.
  - Outputs at reset: TRIGGER all 1, TRIGGERC all 1, TRIGGERE=1, STOP_REQUEST=0, EXTRA_TRIG=0, CNT_SER=0, SER_DONE=0.

## Timing
- Discriminator rising edge sampled at edge k, with TRIG_DELAY=d: the state updates at edge k+1+d. TRIGGER/TRIGGERC change in that same cycle.
- Holdoff H: the first event is accepted no earlier than H cycles after the INST_START edge. H=0 means armed in the first SAMPLING cycle.
- A level held high produces one event only; the next event needs L to return to 0.
- INST_START on the same cycle as an event: the start wins and the event is dropped.
- INST_READOUT: sreg is loaded on that edge, and CNT_SER is valid in the next cycle.
- RSTB asserted mid-operation: everything returns to reset values immediately, with no cycle of delay.

## Structure
- Package psec_pkg holds the seq_state_t enum and the MODE encoding constants, shared with the channel top.
- One sub-module: psec_ser_frame, a parametrised width-FW load/shift serializer with SER_DONE.

## Test plan
- NUM_BANKS=4, MODE=0, HOLDOFF=0, d=0, three pulses: grp steps 1, 2, 3 and TRIGGER walks 0111 to 1011 to 1101 to 1110 (bank 0 at left). A fourth pulse gives SLOW_ONLY, STOP_REQUEST=1, TRIGGERE=0.
- MODE=1, HOLDOFF=10, pulse 5 cycles after start: ignored. Pulse at cycle 12: TRIGGER=1100, TRIGGERC=1100.
- d=7: pulse sampled at edge 20 advances the state at edge 28. A held-high level advances it only once.
- INST_START and an event in the same cycle: grp=0 and trig_cnt=0.
- Two triggers, then INST_READOUT with CNT = 1..5 per field, then FW SER_SHIFT strobes: the bitstream equals {2,5,4,3,2,1} LSB first and SER_DONE=1.
- RSTB low during SAMPLING grp=2: all outputs return to their reset values within the same cycle.
